// File: rtl/digest_serializer.sv
// Egress stage for the SHA-256 accelerator: takes a finished digest in one handshake
// and streams it out one word per handshake, H0 first, with a last-word flag.
module digest_serializer #(
    parameter int WIDTH     = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH*NUM_WORDS-1:0] load_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last
);
    // state | meaning
    // IDLE  | no digest held, load_ready high
    // SEND  | word idx presented on out_data, out_valid high

    localparam int TOTAL = WIDTH * NUM_WORDS;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TOTAL-1:0] buffer;
    logic [IDX_W-1:0] idx;
    logic             load_fire;
    logic             out_fire;
    logic             last_fire;

    assign load_fire = load_valid && load_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_fire) state_nxt = SEND;
            SEND:    if (last_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flags decode from the state register only, so no input reaches an output combinationally.
    always_comb begin
        load_ready = (state == IDLE);
        out_valid  = (state == SEND);
    end

    // The buffer shifts towards the MSB so the next word is always its top slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer   <= '0;
            idx      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load_fire) begin
            out_data <= load_data[TOTAL-1 -: WIDTH];
            buffer   <= load_data << WIDTH;
            idx      <= '0;
            out_last <= 1'b0;
        end else if (last_fire) begin
            out_last <= 1'b0;
        end else if (out_fire) begin
            out_data <= buffer[TOTAL-1 -: WIDTH];
            buffer   <= buffer << WIDTH;
            idx      <= idx + 1'b1;
            out_last <= (idx == LAST_IDX - 1'b1);
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
// Directed bench for digest_serializer: a queue of expected words is filled when a
// digest is accepted and drained as the consumer takes words.
module tb_digest_serializer;
    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_valid;
    logic           load_ready;
    logic [W*N-1:0] load_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;

    logic           v_load_valid;
    logic           v_load_ready;
    logic [15:0]    v_load_data;
    logic           v_out_valid;
    logic           v_out_ready;
    logic [7:0]     v_out_data;
    logic           v_out_last;

    digest_serializer #(.WIDTH(W), .NUM_WORDS(N)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    digest_serializer #(.WIDTH(8), .NUM_WORDS(2)) dut_v (
        .clk(clk), .rst(rst),
        .load_valid(v_load_valid), .load_ready(v_load_ready), .load_data(v_load_data),
        .out_valid(v_out_valid), .out_ready(v_out_ready), .out_data(v_out_data), .out_last(v_out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   words_seen = 0;

    localparam logic [W*N-1:0] H_INIT = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [W*N-1:0] D_BP   = {32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
                                         32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008};
    localparam logic [W*N-1:0] D_RST  = {32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef,
                                         32'hfedcba98, 32'h76543210, 32'h0badc0de, 32'hfeedface};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_digest(input logic [W*N-1:0] d);
        logic [W*N-1:0] tmp;
        tmp = d;
        for (int k = 0; k < N; k++) begin
            sb.push_back({tmp[W*N-1 -: W], (k == N - 1)});
            tmp = tmp << W;
        end
    endtask

    // One clock: sample at the falling edge against the model, then let the rising edge pass.
    task automatic step(input logic rdy);
        logic busy;
        @(negedge clk);
        out_ready = rdy;
        busy = (sb.size() != 0);
        check("out_valid", out_valid, busy);
        check("load_ready", load_ready, !busy);
        if (busy && out_valid) begin
            check("out_data", out_data, sb[0].data);
            check("out_last", out_last, sb[0].last);
            if (rdy) begin
                void'(sb.pop_front());
                words_seen++;
            end
        end
        if (!busy && load_valid) push_digest(load_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step(1'b1);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst          = 1'b1;
        load_valid   = 1'b0;
        load_data    = '0;
        out_ready    = 1'b0;
        v_load_valid = 1'b0;
        v_load_data  = '0;
        v_out_ready  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        repeat (3) step(1'b1);

        // Streaming order, no stalls
        load_valid = 1'b1;
        load_data  = H_INIT;
        step(1'b1);
        load_valid = 1'b0;
        words_seen = 0;
        drain(20);
        check("stream_count", words_seen, 8);
        step(1'b1);

        // Back-pressure on word 2 and on the last word
        load_valid = 1'b1;
        load_data  = D_BP;
        step(1'b1);
        load_valid = 1'b0;
        words_seen = 0;
        repeat (2) step(1'b1);
        repeat (3) step(1'b0);
        repeat (5) step(1'b1);
        repeat (3) step(1'b0);
        step(1'b1);
        check("bp_count", words_seen, 8);
        step(1'b1);

        // Load held high through a whole stream; second digest follows in the first idle cycle
        load_valid = 1'b1;
        load_data  = H_INIT;
        step(1'b1);
        load_data  = {8{32'h11111111}};
        words_seen = 0;
        repeat (9) step(1'b1);
        load_valid = 1'b0;
        check("hold_first_count", words_seen, 8);
        check("hold_second_queued", 64'(sb.size()), 64'd8);
        drain(20);
        check("hold_total_count", words_seen, 16);

        // Reset after word 3 is accepted
        load_valid = 1'b1;
        load_data  = D_RST;
        step(1'b1);
        load_valid = 1'b0;
        words_seen = 0;
        repeat (4) step(1'b1);
        check("pre_rst_count", words_seen, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_load_ready", load_ready, 1'b1);
        check("mid_rst_out_last", out_last, 1'b0);
        check("mid_rst_out_data", out_data, 0);
        load_valid = 1'b1;
        load_data  = D_RST;
        step(1'b1);
        load_valid = 1'b0;
        words_seen = 0;
        drain(20);
        check("post_rst_count", words_seen, 8);

        // WIDTH=8, NUM_WORDS=2 variant
        @(negedge clk);
        check("v_idle_ready", v_load_ready, 1'b1);
        v_load_valid = 1'b1;
        v_load_data  = 16'hA55A;
        v_out_ready  = 1'b1;
        @(negedge clk);
        v_load_valid = 1'b0;
        check("v_w0_valid", v_out_valid, 1'b1);
        check("v_w0_data", v_out_data, 8'hA5);
        check("v_w0_last", v_out_last, 1'b0);
        @(negedge clk);
        check("v_w1_valid", v_out_valid, 1'b1);
        check("v_w1_data", v_out_data, 8'h5A);
        check("v_w1_last", v_out_last, 1'b1);
        @(negedge clk);
        check("v_end_valid", v_out_valid, 1'b0);
        check("v_end_ready", v_load_ready, 1'b1);
        check("v_end_last", v_out_last, 1'b0);
        check("v_end_data", v_out_data, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/digest_serializer.md
# digest_serializer

Parallel-to-serial output stage for the SHA-256 accelerator. Accepts a complete digest (NUM_WORDS words of WIDTH bits) in one handshake and streams it out one word per handshake, H0 first, with a last-word flag. It is the egress counterpart of the fixed-latency word pipelines in the datapath: those take words in and hold them for a fixed number of cycles, while this block takes a finished result and releases it under consumer back-pressure.

## Interface
Parameters:
- WIDTH, 32, bits per output word.
- NUM_WORDS, 8, words per digest; must be at least 2.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  producer has a digest on load_data.
- load_ready  output  1  block can accept a digest; high only in IDLE.
- load_data  input  WIDTH*NUM_WORDS  digest. Word k occupies bits [WIDTH*(NUM_WORDS-k)-1 : WIDTH*(NUM_WORDS-k-1)], so word 0 (H0) is the most significant slice.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  current word, registered.
- out_last  output  1  high together with out_valid on word NUM_WORDS-1.

## Operation
- State machine with two states, IDLE and SEND, plus a word index counter `idx` that is clog2(NUM_WORDS) bits wide.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid&&load_ready: capture all of load_data into an internal shift buffer.
  - Set out_data to word 0, idx=0, out_last=0, then go to SEND.
- SEND:
  - load_ready=0 and out_valid=1.
  - out_data, out_last and the buffer hold stable while out_ready=0. This holds for any length of stall.
  - On out_valid&&out_ready with idx<NUM_WORDS-1: load word idx+1 into out_data, increment idx, and set out_last=(idx+1==NUM_WORDS-1).
  - On out_valid&&out_ready with idx==NUM_WORDS-1: go to IDLE, clear out_valid and out_last, and leave out_data holding the last word.
- load_valid in SEND is ignored; load_data is not sampled.
- load_valid and the final out handshake in the same cycle: the load is not accepted, because load_ready=0. The producer must hold load_valid, and the digest is accepted in the following IDLE cycle.
- rst asserted, including mid-stream:
  - Next state is IDLE; any remaining words are discarded.
  - Outputs after the reset edge: out_valid=0, out_last=0, out_data=0, load_ready=1, idx=0.
- Output behaviour is defined only for out_data and the flags while out_valid=1. The buffer contents are don't-care in IDLE.

## Timing
- Load accepted at edge N → out_valid=1 with word 0 visible after edge N (cycle N+1).
- With out_ready held at 1, word k is accepted at edge N+1+k. The last word is accepted at edge N+NUM_WORDS.
- In the cycle after the last accept, out_valid=0 and load_ready=1.
- Best-case throughput is NUM_WORDS+1 cycles per digest: 9 cycles for the default parameters.
- No combinational path from out_ready or load_valid to any output.
  - load_ready is decoded from the state register only.
  - out_valid, out_data and out_last are registers.

## Test plan
- Reset values: hold rst for 2 cycles, then release. Required: load_ready=1, out_valid=0, out_last=0, out_data=0, and the block stays idle with no load.
- Streaming order, no stalls:
  - Stimulus: load {32'h6a09e667, 32'hbb67ae85, ..., 32'h5be0cd19} with out_ready=1.
  - Required: words appear in that order on 8 consecutive cycles, starting one cycle after the load.
  - Required: out_last=1 only with 32'h5be0cd19, then out_valid=0 and load_ready=1.
- Back-pressure:
  - Stimulus: drop out_ready for 3 cycles while word 2 is presented, and again on the last word.
  - Required: out_data/out_last stay stable through each stall, no word is skipped or duplicated, and the total count is 8.
- Load during SEND:
  - Stimulus: assert load_valid with a second digest of 32'h11111111 × 8 throughout the first stream.
  - Required: load_ready=0 until the last word is accepted, and the first stream is unchanged.
  - Required: the second digest is accepted in the first IDLE cycle and streams immediately after.
- Reset mid-stream:
  - Stimulus: assert rst after word 3 is accepted.
  - Required: the next cycle shows out_valid=0 and load_ready=1.
  - Required: a fresh load afterwards streams from word 0 with idx restarted.
- Parameter variant: WIDTH=8, NUM_WORDS=2, load 16'hA55A. Required: out_data 8'hA5 then 8'h5A, with out_last=1 on 8'h5A.
